// File: rtl/y86_execute_unit.sv
// Y86-64 execute stage: ALU, gated condition codes, cmov/jump condition and E->M register.
// EXEC_MUL_EN adds an iterative shift-add multiplier for OPq ifun 4 (mulq).
module y86_execute_unit #(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic              e_Cnd,
  output logic [3:0]        e_dstE,
  output logic              e_busy,
  output logic [2:0]        CC,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);
  localparam logic [2:0] AOK   = 3'd1;
  localparam logic [2:0] INS   = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4,
                         I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                         I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;

  logic [DATA_W-1:0] aluA, aluB, aluOut;
  logic [1:0]        aluFun;
  logic              aluOf;
  logic              mulOp, mulDone;
  logic [DATA_W-1:0] mulProd;
  logic              insOp, opWrite, ccWrite, cndRaw;
  logic              zf, sf, of;

  always_comb begin
    aluA   = '0;
    aluB   = '0;
    aluFun = 2'd0;
    case (E_icode)
      I_RRMOVQ:           aluA = E_valA;
      I_IRMOVQ:           aluA = E_valC;
      I_RMMOVQ, I_MRMOVQ: begin aluA = E_valC; aluB = E_valB; end
      I_CALL, I_PUSHQ:    begin aluA = DATA_W'(8); aluB = E_valB; aluFun = 2'd1; end
      I_RET, I_POPQ:      begin aluA = DATA_W'(8); aluB = E_valB; end
      I_OPQ: begin
        aluA   = E_valA;
        aluB   = E_valB;
        aluFun = (E_ifun <= 4'd3) ? E_ifun[1:0] : 2'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    aluOut = '0;
    aluOf  = 1'b0;
    case (aluFun)
      2'd0: begin
        aluOut = aluB + aluA;
        aluOf  = (aluA[DATA_W-1] == aluB[DATA_W-1]) && (aluOut[DATA_W-1] != aluA[DATA_W-1]);
      end
      2'd1: begin
        aluOut = aluB - aluA;
        aluOf  = (aluA[DATA_W-1] != aluB[DATA_W-1]) && (aluOut[DATA_W-1] != aluB[DATA_W-1]);
      end
      2'd2:    aluOut = aluB & aluA;
      default: aluOut = aluB ^ aluA;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int N     = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} mulState_t;

  mulState_t         stateReg, stateNext;
  logic [DATA_W-1:0] accReg, accNext, mcandReg, mcandNext, mplierReg, mplierNext;
  logic [CNT_W-1:0]  iterReg, iterNext;
  logic [DATA_W-1:0] stepMcand, stepMplier, stepSum;
  logic [DATA_W-1:0] partial [MUL_STEP];

  assign mulOp = (E_icode == I_OPQ) && (E_ifun == 4'd4) && (E_stat == AOK);

  // The first iteration runs in the IDLE cycle straight from the E operands.
  assign stepMcand  = (stateReg == IDLE) ? E_valB : mcandReg;
  assign stepMplier = (stateReg == IDLE) ? E_valA : mplierReg;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_partial
    assign partial[gi] = stepMplier[gi] ? (stepMcand << gi) : '0;
  end

  always_comb begin
    stepSum = (stateReg == IDLE) ? '0 : accReg;
    for (int j = 0; j < MUL_STEP; j++) stepSum = stepSum + partial[j];
  end

  always_comb begin
    stateNext  = stateReg;
    accNext    = accReg;
    mcandNext  = mcandReg;
    mplierNext = mplierReg;
    iterNext   = iterReg;
    case (stateReg)
      IDLE: if (mulOp) begin
        accNext    = stepSum;
        mcandNext  = stepMcand << MUL_STEP;
        mplierNext = stepMplier >> MUL_STEP;
        iterNext   = CNT_W'(1);
        stateNext  = (N == 1) ? DONE : MUL;
      end
      MUL: begin
        accNext    = stepSum;
        mcandNext  = stepMcand << MUL_STEP;
        mplierNext = stepMplier >> MUL_STEP;
        iterNext   = iterReg + CNT_W'(1);
        if (iterReg == CNT_W'(N - 1)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg  <= IDLE;
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      iterReg   <= '0;
    end else begin
      stateReg  <= stateNext;
      accReg    <= accNext;
      mcandReg  <= mcandNext;
      mplierReg <= mplierNext;
      iterReg   <= iterNext;
    end
  end

  assign e_busy  = (stateReg == MUL) || ((stateReg == IDLE) && mulOp);
  assign mulDone = (stateReg == DONE);
  assign mulProd = accReg;
`else
  assign mulOp   = 1'b0;
  assign e_busy  = 1'b0;
  assign mulDone = 1'b0;
  assign mulProd = '0;
`endif

  assign e_valE = mulDone ? mulProd : aluOut;

  // Undefined OPq functions leave as INS and never touch CC.
  assign insOp   = (E_icode == I_OPQ) && (E_stat == AOK) && (E_ifun > 4'd3) && !mulOp;
  assign opWrite = mulOp ? mulDone : (E_ifun <= 4'd3);
  assign ccWrite = (E_icode == I_OPQ) && (E_stat == AOK) && (m_stat == AOK) &&
                   (W_stat == AOK) && opWrite;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     CC <= 3'b100;
    else if (ccWrite) CC <= {e_valE == '0, e_valE[DATA_W-1], mulDone ? 1'b0 : aluOf};
  end

  assign zf = CC[2];
  assign sf = CC[1];
  assign of = CC[0];

  always_comb begin
    case (E_ifun)
      4'd0:    cndRaw = 1'b1;
      4'd1:    cndRaw = (sf ^ of) | zf;
      4'd2:    cndRaw = sf ^ of;
      4'd3:    cndRaw = zf;
      4'd4:    cndRaw = !zf;
      4'd5:    cndRaw = !(sf ^ of);
      4'd6:    cndRaw = !(sf ^ of) && !zf;
      default: cndRaw = 1'b0;
    endcase
  end

  assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) && cndRaw;
  assign e_dstE = (((E_icode == I_RRMOVQ) && !e_Cnd) || e_busy) ? RNONE : E_dstE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || M_bubble || e_busy) begin
      M_stat  <= AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= insOp ? INS : E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= insOp ? RNONE : e_dstE;
      M_dstM  <= E_dstM;
    end
  end
endmodule

// File: tb/tb_y86_execute_unit.sv
// Self-checking bench for y86_execute_unit against a behavioural model of the execute rules.
// Multiplier scenarios follow EXEC_MUL_EN; the disabled build checks the INS pass-through instead.
module tb_y86_execute_unit;
  localparam int DATA_W = 64;
  localparam int MUL_STEP = 8;
  localparam int N = DATA_W / MUL_STEP;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [143:0] BUBBLE = {3'd1, 4'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};

  logic clock = 1'b0;
  logic reset_n;
  logic [2:0] E_stat, m_stat, W_stat;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic e_Cnd, e_busy, M_Cnd;
  logic [3:0] e_dstE, M_icode, M_dstE, M_dstM;
  logic [2:0] CC, M_stat;
  wire [143:0] mVec = {M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM};

  int checks = 0;
  int errors = 0;
  logic [2:0] mCC;

  y86_execute_unit #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) dut (
    .clock(clock), .reset_n(reset_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble), .e_valE(e_valE), .e_Cnd(e_Cnd),
    .e_dstE(e_dstE), .e_busy(e_busy), .CC(CC), .M_stat(M_stat), .M_icode(M_icode),
    .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  function automatic logic [63:0] refValE(input logic [3:0] icode, input logic [3:0] ifun,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    case (icode)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      4'h6: case (ifun)
        4'd0: return b + a;
        4'd1: return b - a;
        4'd2: return b & a;
        4'd3: return b ^ a;
        4'd4: return b * a;
        default: return b + a;
      endcase
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [2:0] refFlags(input logic [3:0] ifun, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    logic o;
    r = refValE(4'h6, ifun, a, b, 64'd0);
    o = 1'b0;
    if (ifun == 4'd0) o = (a[63] == b[63]) && (r[63] != a[63]);
    if (ifun == 4'd1) o = (a[63] != b[63]) && (r[63] != b[63]);
    return {r == 64'd0, r[63], o};
  endfunction

  function automatic logic refCond(input logic [2:0] cc, input logic [3:0] ifun);
    logic z, s, o;
    {z, s, o} = cc;
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return (s ^ o) | z;
      4'd2: return s ^ o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !(s ^ o);
      4'd6: return !(s ^ o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dE,
                       input logic [3:0] dM, input logic [2:0] st);
    E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = dE; E_dstM = dM; E_stat = st;
  endtask

  task automatic test_reset;
    checks++; if (CC !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b expected 100", CC); end
    checks++; if (mVec !== BUBBLE) begin errors++; $display("FAIL reset_m: got %h expected %h", mVec, BUBBLE); end
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", e_busy); end
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF, AOK);
    @(posedge clock); #1;
    checks++; if (M_icode !== 4'h6) begin errors++; $display("FAIL pre_reset_icode: got %h expected 6", M_icode); end
    #2 reset_n = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
    #1;
    checks++; if (CC !== 3'b100) begin errors++; $display("FAIL async_reset_cc: got %b expected 100", CC); end
    checks++; if (mVec !== BUBBLE) begin errors++; $display("FAIL async_reset_m: got %h expected %h", mVec, BUBBLE); end
    #1 reset_n = 1'b1;
    mCC = 3'b100;
    @(posedge clock); #1;
    $display("reset: CC=%b M_icode=%h", CC, M_icode);
  endtask

  task automatic test_add;
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF, AOK);
    @(negedge clock);
    checks++; if (e_valE !== 64'd12) begin errors++; $display("FAIL add_valE: got %0d expected 12", e_valE); end
    checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL add_dstE: got %h expected 3", e_dstE); end
    @(posedge clock); #1;
    mCC = 3'b000;
    checks++; if (CC !== 3'b000) begin errors++; $display("FAIL add_cc: got %b expected 000", CC); end
    checks++; if (M_valE !== 64'd12) begin errors++; $display("FAIL add_M_valE: got %0d expected 12", M_valE); end
    $display("addq 5+7: e_valE=%0d CC=%b M_valE=%0d", e_valE, CC, M_valE);
  endtask

  task automatic test_cc_gating;
    logic [2:0] gate [3];
    gate[0] = ADR; gate[1] = AOK; gate[2] = AOK;
    for (int i = 0; i < 3; i++) begin
      m_stat = gate[i];
      W_stat = (i == 1) ? HLT : AOK;
      drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 4'hF, AOK);
      @(negedge clock);
      checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_valE[%0d]: got %h expected 7fffffffffffffff", i, e_valE); end
      @(posedge clock); #1;
      if (i == 2) mCC = 3'b001;
      checks++; if (CC !== mCC) begin errors++; $display("FAIL sub_cc[%0d]: got %b expected %b", i, CC, mCC); end
      $display("subq overflow m_stat=%0d W_stat=%0d: CC=%b", m_stat, W_stat, CC);
    end
    m_stat = AOK; W_stat = AOK;
  endtask

  task automatic test_cmov;
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
    @(posedge clock); #1;
    mCC = 3'b010;
    checks++; if (CC !== 3'b010) begin errors++; $display("FAIL cmov_setup_cc: got %b expected 010", CC); end
    drive(4'h2, 4'h2, 64'hABCD, 64'd0, 64'd0, 4'h5, 4'hF, AOK);
    @(negedge clock);
    checks++; if ({e_Cnd, e_dstE, e_valE} !== {1'b1, 4'h5, 64'hABCD}) begin errors++; $display("FAIL cmovl: got cnd=%b dst=%h valE=%h expected cnd=1 dst=5 valE=abcd", e_Cnd, e_dstE, e_valE); end
    @(posedge clock); #1;
    checks++; if (M_dstE !== 4'h5) begin errors++; $display("FAIL cmovl_M_dstE: got %h expected 5", M_dstE); end
    $display("cmovl CC=010: M_Cnd=%b M_dstE=%h", M_Cnd, M_dstE);
    drive(4'h2, 4'h5, 64'hABCD, 64'd0, 64'd0, 4'h5, 4'hF, AOK);
    @(negedge clock);
    checks++; if ({e_Cnd, e_dstE} !== {1'b0, 4'hF}) begin errors++; $display("FAIL cmovge: got cnd=%b dst=%h expected cnd=0 dst=f", e_Cnd, e_dstE); end
    @(posedge clock); #1;
    checks++; if ({M_Cnd, M_dstE} !== {1'b0, 4'hF}) begin errors++; $display("FAIL cmovge_M: got cnd=%b dst=%h expected cnd=0 dst=f", M_Cnd, M_dstE); end
    $display("cmovge CC=010: M_Cnd=%b M_dstE=%h", M_Cnd, M_dstE);
  endtask

  task automatic test_random;
    logic [3:0] icode, ifun, dE, dM;
    logic [63:0] a, b, c, exValE;
    logic [2:0] st;
    logic exCnd, bub, defd;
    logic [3:0] exDst;
    logic [143:0] exVec, acVec;
    for (int t = 0; t < 300; t++) begin
      icode = 4'($urandom_range(0, 11));
      ifun = (icode == 4'h6) ? 4'($urandom_range(0, 3)) :
             ((icode == 4'h2 || icode == 4'h7) ? 4'($urandom_range(0, 7)) : 4'h0);
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = {b[63], 63'd0} | 64'(b[15:0]);
      c = {$urandom, $urandom};
      dE = 4'($urandom); dM = 4'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : AOK;
      m_stat = ($urandom_range(0, 6) == 0) ? ADR : AOK;
      W_stat = ($urandom_range(0, 6) == 0) ? HLT : AOK;
      bub = ($urandom_range(0, 9) == 0);
      M_bubble = bub;
      drive(icode, ifun, a, b, c, dE, dM, st);
      exValE = refValE(icode, ifun, a, b, c);
      exCnd = (icode == 4'h2 || icode == 4'h7) ? refCond(mCC, ifun) : 1'b0;
      exDst = (icode == 4'h2 && !exCnd) ? 4'hF : dE;
      defd = !(icode == 4'h0 || icode == 4'h1 || icode == 4'h7);
      @(negedge clock);
      if (defd) begin
        checks++; if (e_valE !== exValE) begin errors++; $display("FAIL rand_valE[%0d]: icode=%h ifun=%h got %h expected %h", t, icode, ifun, e_valE, exValE); end
      end
      checks++; if ({e_Cnd, e_dstE, e_busy} !== {exCnd, exDst, 1'b0}) begin errors++; $display("FAIL rand_cnd_dst[%0d]: icode=%h ifun=%h got cnd=%b dst=%h busy=%b expected cnd=%b dst=%h busy=0", t, icode, ifun, e_Cnd, e_dstE, e_busy, exCnd, exDst); end
      if (icode == 4'h6 && st == AOK && m_stat == AOK && W_stat == AOK) mCC = refFlags(ifun, a, b);
      exVec = bub ? BUBBLE : {st, icode, exCnd, exValE, a, exDst, dM};
      @(posedge clock); #1;
      acVec = {M_stat, M_icode, M_Cnd, (defd || bub) ? M_valE : exValE, M_valA, M_dstE, M_dstM};
      checks++; if (CC !== mCC) begin errors++; $display("FAIL rand_cc[%0d]: got %b expected %b", t, CC, mCC); end
      checks++; if (acVec !== exVec) begin errors++; $display("FAIL rand_M[%0d]: got %h expected %h", t, acVec, exVec); end
      $display("rand %0d: icode=%h ifun=%h stat=%0d bub=%b valE=%h cnd=%b CC=%b", t, icode, ifun, st, bub, e_valE, e_Cnd, CC);
    end
    M_bubble = 1'b0; m_stat = AOK; W_stat = AOK;
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul;
    logic [63:0] a, b, p;
    int busy;
    bit done;
    drive(4'h6, 4'h4, 64'd9, 64'd4, 64'd0, 4'h4, 4'hF, ADR);
    @(negedge clock);
    checks++; if ({e_busy, e_valE} !== {1'b0, 64'd13}) begin errors++; $display("FAIL mul_nonaok: got busy=%b valE=%0d expected busy=0 valE=13", e_busy, e_valE); end
    @(posedge clock); #1;
    checks++; if ({M_stat, CC} !== {ADR, mCC}) begin errors++; $display("FAIL mul_nonaok_M: got stat=%0d CC=%b expected stat=3 CC=%b", M_stat, CC, mCC); end
    $display("mulq with ADR status: M_stat=%0d M_valE=%0d", M_stat, M_valE);
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom};
      b = (i == 0) ? 64'd7 : {$urandom, $urandom};
      p = a * b;
      drive(4'h6, 4'h4, a, b, 64'd0, 4'h4, 4'hF, AOK);
      busy = 0; done = 0;
      for (int cyc = 0; cyc < 3 * N && !done; cyc++) begin
        @(negedge clock);
        if (e_busy) begin
          busy++;
          checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL mul_busy_dstE[%0d]: got %h expected f", i, e_dstE); end
          @(posedge clock); #1;
          checks++; if (mVec !== BUBBLE) begin errors++; $display("FAIL mul_busy_M[%0d]: got %h expected %h", i, mVec, BUBBLE); end
        end else done = 1;
      end
      checks++; if (busy != N || !done) begin errors++; $display("FAIL mul_busy_cycles[%0d]: got %0d done=%0d expected %0d done=1", i, busy, done, N); end
      if (done) begin
        checks++; if ({e_valE, e_dstE} !== {p, 4'h4}) begin errors++; $display("FAIL mul_done_valE[%0d]: got %h dst=%h expected %h dst=4", i, e_valE, e_dstE, p); end
        M_bubble = (i == 3);
        @(posedge clock); #1;
        M_bubble = 1'b0;
        if (i == 3) begin
          checks++; if (mVec !== BUBBLE) begin errors++; $display("FAIL mul_squash_M: got %h expected %h", mVec, BUBBLE); end
        end else begin
          checks++; if ({M_stat, M_icode, M_valE, M_dstE} !== {AOK, 4'h6, p, 4'h4}) begin errors++; $display("FAIL mul_M[%0d]: got valE=%h dst=%h expected %h dst=4", i, M_valE, M_dstE, p); end
          checks++; if (CC !== refFlags(4'h4, a, b)) begin errors++; $display("FAIL mul_cc[%0d]: got %b expected %b", i, CC, refFlags(4'h4, a, b)); end
        end
      end
      $display("mulq %0d: a=%h b=%h busy=%0d M_valE=%h CC=%b", i, a, b, busy, M_valE, CC);
      drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
      @(negedge clock);
      checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL mul_idle[%0d]: got busy=%b expected 0", i, e_busy); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [63:0] a, b, p;
    int busy;
    bit done;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; p = a * b;
    drive(4'h6, 4'h4, a, b, 64'd0, 4'h6, 4'hF, AOK);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (e_busy !== 1'b1) begin errors++; $display("FAIL midmul_busy: got %b expected 1", e_busy); end
    reset_n = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
    #1;
    mCC = 3'b100;
    checks++; if ({e_busy, CC, mVec} !== {1'b0, 3'b100, BUBBLE}) begin errors++; $display("FAIL midmul_reset: got busy=%b CC=%b M=%h expected busy=0 CC=100 M=bubble", e_busy, CC, mVec); end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    drive(4'h6, 4'h4, a, b, 64'd0, 4'h6, 4'hF, AOK);
    busy = 0; done = 0;
    for (int cyc = 0; cyc < 3 * N && !done; cyc++) begin
      @(negedge clock);
      if (e_busy) begin busy++; @(posedge clock); #1; end
      else done = 1;
    end
    checks++; if (busy != N || !done) begin errors++; $display("FAIL midmul_reissue_busy: got %0d expected %0d", busy, N); end
    if (done) begin
      checks++; if (e_valE !== p) begin errors++; $display("FAIL midmul_reissue_valE: got %h expected %h", e_valE, p); end
      @(posedge clock); #1;
      checks++; if ({M_valE, CC} !== {p, refFlags(4'h4, a, b)}) begin errors++; $display("FAIL midmul_reissue_M: got %h CC=%b expected %h CC=%b", M_valE, CC, p, refFlags(4'h4, a, b)); end
    end
    $display("reset mid-mul then reissue: a=%h b=%h M_valE=%h", a, b, M_valE);
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
    @(posedge clock); #1;
  endtask
`else
  task automatic test_no_mul;
    int busySeen;
    busySeen = 0;
    drive(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'd0, 4'h4, 4'hF, AOK);
    for (int cyc = 0; cyc < N + 2; cyc++) begin
      @(negedge clock);
      if (e_busy !== 1'b0) busySeen++;
      @(posedge clock); #1;
      checks++; if ({M_stat, M_dstE, CC} !== {INS, 4'hF, mCC}) begin errors++; $display("FAIL nomul_M[%0d]: got stat=%0d dst=%h CC=%b expected stat=4 dst=f CC=%b", cyc, M_stat, M_dstE, CC, mCC); end
    end
    checks++; if (busySeen != 0) begin errors++; $display("FAIL nomul_busy: got %0d busy cycles expected 0", busySeen); end
    $display("OPq ifun 4 without multiplier: M_stat=%0d M_dstE=%h CC=%b", M_stat, M_dstE, CC);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    M_bubble = 1'b0;
    m_stat = AOK;
    W_stat = AOK;
    mCC = 3'b100;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, AOK);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    test_reset;
    test_add;
    test_cc_gating;
    test_cmov;
    test_random;
`ifdef EXEC_MUL_EN
    test_mul;
    test_reset_mid_mul;
`else
    test_no_mul;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
